alu_seq_flags: RTL and testbench
================================

# alu_seq_flags

Registered, parametrised M-bit ALU with a 5-bit flag word {N,Z,C,V,P}. It extends the four-op combinational ALU to eight opcodes (XOR, single-bit shifts, and an iterative unsigned multiply) behind a start/busy/done handshake. Results and flags are held in registers until the next operation completes. It sits between the operand-entry/button logic and the 7-segment/LED display path in lab designs.

## Interface
- `M`, default 8: operand width; legal range is ≥ 2.
- `clk`  in  1  system clock; all registers update on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state and outputs.
- `start`  in  1  request one operation; sampled only while `busy` = 0.
- `A`  in  M  operand A, unsigned or two's complement depending on the op.
- `B`  in  M  operand B; ignored by SHL and SHR.
- `OpCode`  in  3  000 SUB (A−B), 001 ADD, 010 OR, 011 AND, 100 XOR, 101 SHL1 (A<<1), 110 SHR1 (A>>1 logical), 111 MUL (unsigned A×B).
- `busy`  out  1  high while a multiply is iterating.
- `done`  out  1  one-cycle pulse when `Result`, `ResultHi` and `Flags` update.
- `Result`  out  M  low M bits of the result.
- `ResultHi`  out  M  high M bits of the MUL product; 0 for all other ops.
- `Flags`  out  5  {N,Z,C,V,P}.

## Operation
- FSM has two states: IDLE and MUL.
- **IDLE, `start` = 1, OpCode ≠ 111:** compute from the live A, B and OpCode, register Result, ResultHi = 0 and Flags, pulse `done`. Stay in IDLE.
- **IDLE, `start` = 1, OpCode = 111:** capture A and B, clear the 2M-bit accumulator, load count = 0, go to MUL.
- **MUL:** one shift-add step per cycle, consuming one multiplier bit LSB-first. After step M, write {ResultHi, Result} = product, pulse `done`, return to IDLE.
- `start` while in MUL is ignored; it is not queued.
- Outputs are held unchanged between `done` pulses.
- Arithmetic for ADD and SUB is M+1 bits wide. Bit M is the carry for ADD and the borrow for SUB (1 when A < B unsigned).
- Flag rules:
  - **N:** Result[M−1]. For MUL, ResultHi[M−1].
  - **Z:** 1 when Result == 0. For MUL, 1 only when the full 2M-bit product == 0.
  - **C:** ADD carry; SUB borrow; SHL A[M−1]; SHR A[0]; MUL (ResultHi ≠ 0); logic ops 0.
  - **V:** ADD (¬A₇·¬B₇·R₇ + A₇·B₇·¬R₇); SUB (¬A₇·B₇·R₇ + A₇·¬B₇·¬R₇), with bit 7 meaning bit M−1; SHL A[M−1]⊕A[M−2]; all others 0.
  - **P:** XOR-reduction of Result (low half only); 1 means odd parity.
- **Reset (any time, including mid-MUL):** state = IDLE; busy, done, Result, ResultHi and Flags all 0 (Z is explicitly 0 at reset). Any multiply in flight is aborted with no `done`.

## Timing
- Define k as the rising edge at which `start` is sampled high in IDLE.
- **Non-MUL ops:** outputs valid and `done` = 1 in the cycle after edge k. Latency is 1 and `busy` stays 0.
- **MUL:** `busy` = 1 in the cycles after edges k … k+M−1, i.e. M cycles. Steps execute at edges k+1 … k+M. At edge k+M, outputs update, `done` = 1 and `busy` = 0. Latency is M.
- `done` is high for exactly one cycle. A new `start` may be sampled in the same cycle that `done` is high; back-to-back single-cycle ops give `done` on consecutive cycles.
- There are no combinational paths from inputs to outputs.

## Test plan
All values below use M = 8.
- **Reset values:** assert `reset`, then release → Result = 0x00, ResultHi = 0x00, Flags = 5'b00000, busy = 0, done = 0.
- **ADD:** 0xFF + 0x01 → Result 0x00, Flags 5'b01100 (Z,C); `done` one cycle after start. Then 0x7F + 0x01 → 0x80, Flags 5'b10011 (N,V,P).
- **SUB:** 0x80 − 0x01 → 0x7F, Flags 5'b00011 (V,P). Then 0x01 − 0x02 → 0xFF, Flags 5'b10100 (N,C).
- **Shifts and logic:** SHL1 0xC0 → 0x80, Flags 5'b10101. SHR1 0x01 → 0x00, Flags 5'b01100. XOR 0xAA^0xAA → 0x00, Flags 5'b01000. AND 0xF0&0x3C → 0x30, Flags 5'b00000.
- **MUL:** 0xFF × 0xFF → ResultHi 0xFE, Result 0x01, Flags 5'b10101. `busy` is high for 8 cycles and `done` appears 8 edges after start. A `start` pulsed mid-multiply is ignored. 0x0F × 0x11 → 0x00/0xFF, Flags 5'b00000.
- **Reset mid-MUL:** assert `reset` 4 cycles into a multiply → all outputs 0 immediately (asynchronous), no `done` pulse. After release, ADD 0x02 + 0x03 → 0x05, Flags 5'b00000.

Source files
------------

// File: rtl/alu_seq_flags.sv
// Registered M-bit ALU with {N,Z,C,V,P} flags and a start/busy/done handshake.
// Single-cycle ops finish in one edge; MUL iterates one shift-add step per cycle.
module alu_seq_flags #(
  parameter int M = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [M-1:0] A,
  input  logic [M-1:0] B,
  input  logic [2:0]   OpCode,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] Result,
  output logic [M-1:0] ResultHi,
  output logic [4:0]   Flags
);

  localparam int CW = $clog2(M);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t         state_q;
  logic [2*M-1:0] mcand_q;
  logic [M-1:0]   mplier_q;
  logic [2*M-1:0] acc_q;
  logic [CW-1:0]  cnt_q;
  logic [M-1:0]   res_q;
  logic [M-1:0]   hi_q;
  logic [4:0]     flags_q;
  logic           done_q;
  logic           busy_q;

  logic [M:0]     sum;
  logic [M:0]     diff;
  logic [M-1:0]   alu_res;
  logic           alu_c;
  logic           alu_v;
  logic [4:0]     alu_flags;
  logic [2*M-1:0] acc_d;
  logic [4:0]     mul_flags;

  // Bit M of sum is the carry; bit M of diff is the borrow (A < B unsigned).
  always_comb begin
    sum     = {1'b0, A} + {1'b0, B};
    diff    = {1'b0, A} - {1'b0, B};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (OpCode)
      3'b000: begin
        alu_res = diff[M-1:0];
        alu_c   = diff[M];
        alu_v   = (~A[M-1] & B[M-1] & diff[M-1]) | (A[M-1] & ~B[M-1] & ~diff[M-1]);
      end
      3'b001: begin
        alu_res = sum[M-1:0];
        alu_c   = sum[M];
        alu_v   = (~A[M-1] & ~B[M-1] & sum[M-1]) | (A[M-1] & B[M-1] & ~sum[M-1]);
      end
      3'b010: alu_res = A | B;
      3'b011: alu_res = A & B;
      3'b100: alu_res = A ^ B;
      3'b101: begin
        alu_res = {A[M-2:0], 1'b0};
        alu_c   = A[M-1];
        alu_v   = A[M-1] ^ A[M-2];
      end
      3'b110: begin
        alu_res = {1'b0, A[M-1:1]};
        alu_c   = A[0];
      end
      default: alu_res = '0;
    endcase
    alu_flags = {alu_res[M-1], (alu_res == '0), alu_c, alu_v, ^alu_res};
  end

  // The final step's sum is the product, so flags are taken from acc_d directly.
  assign acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_flags = {acc_d[2*M-1], (acc_d == '0), (acc_d[2*M-1:M] != '0), 1'b0, ^acc_d[M-1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
      hi_q     <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (OpCode == 3'b111) begin
              mcand_q  <= {{M{1'b0}}, A};
              mplier_q <= B;
              acc_q    <= '0;
              cnt_q    <= '0;
              busy_q   <= 1'b1;
              state_q  <= S_MUL;
            end else begin
              res_q   <= alu_res;
              hi_q    <= '0;
              flags_q <= alu_flags;
              done_q  <= 1'b1;
            end
          end
        end
        S_MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == CW'(M - 1)) begin
            res_q   <= acc_d[M-1:0];
            hi_q    <= acc_d[2*M-1:M];
            flags_q <= mul_flags;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign Result   = res_q;
  assign ResultHi = hi_q;
  assign Flags    = flags_q;

endmodule

// File: tb/tb_alu_seq_flags.sv
// Bench for alu_seq_flags: arithmetic reference model checked every cycle,
// directed literal cases from the test plan, then randomized traffic.
module tb_alu_seq_flags;

  localparam int M    = 8;
  localparam int MASK = (1 << M) - 1;
  localparam int HALF = 1 << (M - 1);

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [M-1:0] A = '0;
  logic [M-1:0] B = '0;
  logic [2:0]   OpCode = '0;
  logic         busy;
  logic         done;
  logic [M-1:0] Result;
  logic [M-1:0] ResultHi;
  logic [4:0]   Flags;

  int tests = 0;
  int fails = 0;

  alu_seq_flags #(.M(M)) dut (
    .clk(clk), .reset(reset), .start(start), .A(A), .B(B), .OpCode(OpCode),
    .busy(busy), .done(done), .Result(Result), .ResultHi(ResultHi), .Flags(Flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Returns {hi, lo, N, Z, C, V, P} from plain integer arithmetic.
  function automatic logic [2*M+4:0] model(input logic [2:0] op, input logic [M-1:0] a, input logic [M-1:0] b);
    int ua, ub, sa, sb, s, r, lo, hi;
    bit n, z, c, v, p;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= HALF) ? ua - (1 << M) : ua;
    sb = (ub >= HALF) ? ub - (1 << M) : ub;
    hi = 0; c = 0; v = 0; r = 0;
    case (op)
      3'd0: begin r = ua - ub; c = (ua < ub); s = sa - sb; v = (s < -HALF) || (s > HALF - 1); end
      3'd1: begin r = ua + ub; c = (r > MASK); s = sa + sb; v = (s < -HALF) || (s > HALF - 1); end
      3'd2: r = ua | ub;
      3'd3: r = ua & ub;
      3'd4: r = ua ^ ub;
      3'd5: begin r = ua * 2; c = (ua >= HALF); v = (((r & MASK) >= HALF) != (ua >= HALF)); end
      3'd6: begin r = ua / 2; c = (ua % 2) == 1; end
      default: begin r = ua * ub; hi = r >> M; c = (hi != 0); end
    endcase
    lo = r & MASK;
    if (op == 3'd7) begin
      n = (hi >= HALF);
      z = (r == 0);
    end else begin
      n = (lo >= HALF);
      z = (lo == 0);
    end
    p = ($countones(lo) % 2) == 1;
    return {hi[M-1:0], lo[M-1:0], n, z, c, v, p};
  endfunction

  // Expected outputs, advanced on the same edges the DUT uses.
  logic [M-1:0] e_res, e_hi, m_a, m_b;
  logic [4:0]   e_flags;
  logic         e_done, e_busy;
  int           e_left;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      e_res <= '0; e_hi <= '0; e_flags <= '0;
      e_done <= 1'b0; e_busy <= 1'b0; e_left <= 0;
    end else begin
      e_done <= 1'b0;
      if (e_busy) begin
        if (e_left == 1) begin
          {e_hi, e_res, e_flags} <= model(3'd7, m_a, m_b);
          e_done <= 1'b1;
          e_busy <= 1'b0;
        end
        e_left <= e_left - 1;
      end else if (start) begin
        if (OpCode == 3'd7) begin
          m_a <= A; m_b <= B; e_busy <= 1'b1; e_left <= M;
        end else begin
          {e_hi, e_res, e_flags} <= model(OpCode, A, B);
          e_done <= 1'b1;
        end
      end
    end
  end

  bit cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc done", 32'(done), 32'(e_done));
      check("cyc busy", 32'(busy), 32'(e_busy));
      check("cyc Result", 32'(Result), 32'(e_res));
      check("cyc ResultHi", 32'(ResultHi), 32'(e_hi));
      check("cyc Flags", 32'(Flags), 32'(e_flags));
    end
  end

  // Issues one op and waits (bounded) for done; edges counts edges after k.
  task automatic run_op(input string name, input logic [2:0] op, input logic [M-1:0] a, input logic [M-1:0] b,
                        input logic [M-1:0] x_hi, input logic [M-1:0] x_res, input logic [4:0] x_flags,
                        input int x_edges, input bit mid_start);
    int waited, busy_cnt;
    bit seen;
    @(negedge clk);
    start = 1'b1; OpCode = op; A = a; B = b;
    @(negedge clk);
    start = 1'b0;
    waited = 1; busy_cnt = 0; seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
      start = (mid_start && waited == 3);
      @(negedge clk);
      waited++;
    end
    start = 1'b0;
    $display("[TB] %s: A=%h B=%h -> hi=%h res=%h flags=%b after %0d edges", name, a, b, ResultHi, Result, Flags, waited - 1);
    check({name, " done seen"}, 32'(seen), 32'd1);
    check({name, " latency"}, 32'(waited - 1), 32'(x_edges));
    if (op == 3'd7) check({name, " busy cycles"}, 32'(busy_cnt), 32'(M));
    check({name, " Result"}, 32'(Result), 32'(x_res));
    check({name, " ResultHi"}, 32'(ResultHi), 32'(x_hi));
    check({name, " Flags"}, 32'(Flags), 32'(x_flags));
  endtask

  initial begin
    check("model ADD ff+01", 32'(model(3'd1, 8'hFF, 8'h01)), 32'({8'h00, 8'h00, 5'b01100}));
    check("model SUB 01-02", 32'(model(3'd0, 8'h01, 8'h02)), 32'({8'h00, 8'hFF, 5'b10100}));
    check("model MUL ff*ff", 32'(model(3'd7, 8'hFF, 8'hFF)), 32'({8'hFE, 8'h01, 5'b10101}));

    repeat (2) @(negedge clk);
    reset = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);
    check("reset Result", 32'(Result), 32'h0);
    check("reset ResultHi", 32'(ResultHi), 32'h0);
    check("reset Flags", 32'(Flags), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset done", 32'(done), 32'h0);

    run_op("ADD ff+01", 3'd1, 8'hFF, 8'h01, 8'h00, 8'h00, 5'b01100, 0, 1'b0);
    run_op("ADD 7f+01", 3'd1, 8'h7F, 8'h01, 8'h00, 8'h80, 5'b10011, 0, 1'b0);
    run_op("SUB 80-01", 3'd0, 8'h80, 8'h01, 8'h00, 8'h7F, 5'b00011, 0, 1'b0);
    run_op("SUB 01-02", 3'd0, 8'h01, 8'h02, 8'h00, 8'hFF, 5'b10100, 0, 1'b0);
    run_op("SHL c0", 3'd5, 8'hC0, 8'h00, 8'h00, 8'h80, 5'b10101, 0, 1'b0);
    run_op("SHR 01", 3'd6, 8'h01, 8'h00, 8'h00, 8'h00, 5'b01100, 0, 1'b0);
    run_op("XOR aa^aa", 3'd4, 8'hAA, 8'hAA, 8'h00, 8'h00, 5'b01000, 0, 1'b0);
    run_op("AND f0&3c", 3'd3, 8'hF0, 8'h3C, 8'h00, 8'h30, 5'b00000, 0, 1'b0);
    run_op("MUL ff*ff", 3'd7, 8'hFF, 8'hFF, 8'hFE, 8'h01, 5'b10101, M, 1'b1);
    run_op("MUL 0f*11", 3'd7, 8'h0F, 8'h11, 8'h00, 8'hFF, 5'b00000, M, 1'b0);

    // Reset four cycles into a multiply: outputs clear without waiting for an edge.
    @(negedge clk);
    start = 1'b1; OpCode = 3'd7; A = 8'hFF; B = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("midmul busy before reset", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("midmul reset Result", 32'(Result), 32'h0);
    check("midmul reset ResultHi", 32'(ResultHi), 32'h0);
    check("midmul reset Flags", 32'(Flags), 32'h0);
    check("midmul reset busy", 32'(busy), 32'h0);
    check("midmul reset done", 32'(done), 32'h0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    repeat (M + 2) begin
      @(negedge clk);
      check("no done after abort", 32'(done), 32'h0);
    end
    run_op("ADD 02+03", 3'd1, 8'h02, 8'h03, 8'h00, 8'h05, 5'b00000, 0, 1'b0);

    // Random traffic, including starts during MUL and back-to-back ops.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      start  = ($urandom_range(0, 3) != 0);
      OpCode = 3'($urandom_range(0, 7));
      A      = 8'($urandom);
      B      = 8'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (M + 3) @(negedge clk);

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
